pc_fetch_sequencer: RTL

Multi-cycle fetch controller that owns the architectural program counter and sequences instruction fetch for the ARMv8 core. It issues one request per instruction to instruction memory over a valid/ready channel, holds the returned instruction for the datapath, and commits the next-PC value produced by the next-PC logic when the datapath signals completion. It also detects halt, misaligned targets and memory timeouts, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/pc_fetch_sequencer_if.sv | 39 +++
 rtl/fetch_timeout_counter.sv | 46 ++++
 rtl/pc_fetch_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
//============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the fetch sequencer: FSM state
//               encoding, default instruction width, PC alignment mask and a
//               saturating increment helper for the retire counter.
// Revision    : 1.0 - initial release
//============================================================================
package cpu_pkg;

    // Encoding is architecturally visible on the debug 'state' output
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EXEC = 3'd3,
        ST_HALT = 3'd4,
        ST_ERR  = 3'd5
    } fetch_state_t;

    localparam int          INSTR_W_DEF   = 32;
    localparam logic [63:0] PC_ALIGN_MASK = 64'h3;

    // Retire count sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
//============================================================================
// Module      : pc_fetch_sequencer_if
// Description : Instruction-memory channel: valid/ready request carrying the
//               fetch address, plus a valid-qualified response data return.
// Revision    : 1.0 - initial release
//============================================================================
interface pc_fetch_sequencer_if
    import cpu_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
) ();

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [63:0]        imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    // Fetch side: issues requests, consumes responses
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Memory side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/fetch_timeout_counter.sv
`default_nettype none
//============================================================================
// Module      : fetch_timeout_counter
// Description : 16-bit wait-cycle counter. tc_o is high during the
//               TIMEOUT_CYC-th enabled cycle after a clear, so the caller can
//               leave on that edge after exactly TIMEOUT_CYC wait cycles.
// Revision    : 1.0 - initial release
//============================================================================
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [15:0] TC_VAL = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Clear dominates; counting stops at the terminal value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
//============================================================================
// Module      : pc_fetch_sequencer
// Description : Multi-cycle fetch controller. Owns the architectural PC,
//               issues one instruction-memory request per instruction, holds
//               the returned instruction for the datapath and commits the
//               next PC on completion. Flags halt, misaligned targets and
//               memory timeouts; counts retired instructions (saturating).
// Revision    : 1.0 - initial release
//============================================================================
module pc_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int INSTR_W     = INSTR_W_DEF
) (
    input  logic                 CLK,
    input  logic                 resetl,
    input  logic                 run,
    input  logic [63:0]          startpc,
    pc_fetch_sequencer_if.master imem,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    input  logic                 ex_done,
    input  logic [63:0]          next_pc,
    input  logic                 halt,
    output logic [63:0]          currentpc,
    output logic [2:0]           state,
    output logic [31:0]          retired,
    output logic                 fetch_err
);

    fetch_state_t       state_q,   state_d;
    logic [63:0]        pc_q,      pc_d;
    logic [31:0]        retired_q, retired_d;
    logic [INSTR_W-1:0] instr_q,   instr_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_tc;

    fetch_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i  (CLK),
        .rst_ni (resetl),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    // Next-state and datapath-update decode; inputs are only looked at in
    // the state that owns them, everything else holds
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        instr_d   = instr_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    if (|(startpc & PC_ALIGN_MASK)) begin
                        state_d = ST_ERR;
                    end else begin
                        pc_d      = startpc;
                        retired_d = '0;
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (imem.imem_req_ready) begin
                    tmr_clr = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the terminal cycle still wins over timeout
                if (imem.imem_rsp_valid) begin
                    instr_d = imem.imem_rsp_data;
                    state_d = ST_EXEC;
                end else if (tmr_tc) begin
                    state_d = ST_ERR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    if (halt) begin
                        retired_d = sat_inc32(retired_q);
                        state_d   = ST_HALT;
                    end else if (|(next_pc & PC_ALIGN_MASK)) begin
                        state_d = ST_ERR;
                    end else begin
                        pc_d      = next_pc;
                        retired_d = sat_inc32(retired_q);
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            retired_q <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            instr_q   <= instr_d;
        end
    end

    // Moore outputs: decoded from registered state only
    assign imem.imem_req_valid = (state_q == ST_REQ);
    assign imem.imem_req_addr  = pc_q;
    assign instr_valid         = (state_q == ST_EXEC);
    assign fetch_err           = (state_q == ST_ERR);
    assign state               = state_q;
    assign currentpc           = pc_q;
    assign retired             = retired_q;
    assign instr               = instr_q;

endmodule
`default_nettype wire
